main_decoder: RTL and testbench
===============================

MAIN_DECODER -- requirements
Module: main_decoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset. `clk`, input, 1: rising-edge clock.
REQ-003 `rst`, input, 1: synchronous active-low reset.
REQ-004 `op`, input, 7: instruction opcode field, instr[6:0].
REQ-005 `ResultSrc`, output, 2: writeback select; 00 = ALU, 01 = memory, 10 = PC+4, 11 = U-immediate.
REQ-006 `MemWrite`, output, 1: data-memory write enable.
REQ-007 `Branch`, output, 1: conditional-branch instruction.
REQ-008 `ALUSrc`, output, 1: ALU operand B select; 0 = rs2, 1 = immediate.
REQ-009 `RegWrite`, output, 1: register-file write enable.
REQ-010 `Jump`, output, 1: unconditional jump (jal/jalr).
REQ-011 `ImmSrc`, output, 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
REQ-012 `ALUop`, output, 2: to the ALU decoder; 00 = add, 01 = subtract/compare, 10 = use funct3/funct7.
REQ-013 `Illegal`, output, 1: opcode not in the decode table.

Function
REQ-014 The decode SHALL be a pure function of `op`; all outputs are registered, and `op` sampled at rising edge N appears on the outputs after edge N.
REQ-015 The latency SHALL be exactly 1 cycle; a new `op` is accepted every cycle; there is no handshake.
REQ-016 Each opcode SHALL produce the following control word, given as RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUop, Jump, Illegal:
- R-type 0110011: 1,00,0,0,00,0,10,0,0
- I-ALU 0010011: 1,00,1,0,00,0,10,0,0
- lw 0000011: 1,00,1,0,01,0,00,0,0
- sw 0100011: 0,01,1,1,00,0,00,0,0
- beq 1100011: 0,10,0,0,00,1,01,0,0
- jal 1101111: 1,11,0,0,10,0,00,1,0
- jalr 1100111: 1,00,1,0,10,0,00,1,0 (the ALU computes rs1+imm as the target)
- lui 0110111: 1,00,1,0,11,0,00,0,0 (the datapath supplies instr[31:12]<<12 on ResultSrc=11)
REQ-017 Any other opcode, including 0000000 and 1111111, SHALL produce all control outputs 0 and Illegal = 1, so that no architectural state is written.
REQ-018 The outputs SHALL never be X for any 7-bit `op`; the decode uses a full case with a default.
REQ-019 The outputs SHALL hold their value between edges regardless of `op` glitches.

Reset
REQ-020 When `rst` = 0 at a rising edge, all outputs SHALL become 0, including Illegal.
REQ-021 Reset SHALL take priority over decode; the first decode appears at the first rising edge with `rst` = 1.
REQ-022 Asserting reset mid-stream SHALL clear the outputs at that edge, and no partial word SHALL survive.

Structure
REQ-023 A shared package SHALL hold the opcode constants, the ResultSrc, ImmSrc and ALUop encodings, and a packed control-word typedef.
REQ-024 The design SHALL have one natural sub-module, `main_decoder_comb`: a combinational op-to-control-word table. The top-level module adds the output register and reset.

Verification
REQ-025 Reset: `rst` = 0 for 2 cycles with op = 0110011 -> all outputs 0; release -> next edge gives RegWrite=1, ALUop=10, Illegal=0.
REQ-026 lw then sw on consecutive cycles -> ResultSrc=01, ALUSrc=1, RegWrite=1, then MemWrite=1, ImmSrc=01, RegWrite=0, each one cycle after its `op`.
REQ-027 beq, jal, jalr, lui in sequence -> Branch=1/ALUop=01, Jump=1/ImmSrc=11/ResultSrc=10, Jump=1/ALUSrc=1/ImmSrc=00, ResultSrc=11/ALUSrc=1.
REQ-028 op = 0000000 and op = 1111111 -> all controls 0, Illegal=1.
REQ-029 Exhaustive sweep of all 128 opcodes -> exactly 8 give Illegal=0 with the words in REQ-016; no X on any output.
REQ-030 Reset asserted while decoding jal -> outputs 0 at that edge; after release, op = I-ALU -> 1,00,1,0,00,0,10,0,0.

Source files
------------

// File: rtl/main_decoder_pkg.sv
// Shared definitions for the RV32 main decoder: opcode constants, control
// field encodings and the packed control word carried from table to register.
package main_decoder_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_UIMM = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    // Field order matches the conventional control-word listing, MSB first.
    typedef struct packed {
        logic        reg_write;
        imm_src_e    imm_src;
        logic        alu_src;
        logic        mem_write;
        result_src_e result_src;
        logic        branch;
        alu_op_e     alu_op;
        logic        jump;
        logic        illegal;
    } ctrl_t;

endpackage

// File: rtl/main_decoder_comb.sv
// Combinational opcode-to-control-word table; unknown opcodes decode to an
// all-zero word with only the illegal flag raised.
module main_decoder_comb
    import main_decoder_pkg::*;
(
    input  logic [6:0] op_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        // NOTE: the default assignment ahead of the case gives every output a
        // value on every path, so no latch can be inferred.
        ctrl_o         = '0;
        ctrl_o.illegal = 1'b1;
        case (op_i)
            OP_R_TYPE: begin
                ctrl_o.illegal   = 1'b0;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            OP_I_ALU: begin
                ctrl_o.illegal   = 1'b0;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                ctrl_o.illegal    = 1'b0;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_MEM;
            end
            OP_SW: begin
                ctrl_o.illegal   = 1'b0;
                ctrl_o.imm_src   = IMM_S;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.illegal = 1'b0;
                ctrl_o.imm_src = IMM_B;
                ctrl_o.branch  = 1'b1;
                ctrl_o.alu_op  = ALU_SUB;
            end
            OP_JAL: begin
                ctrl_o.illegal    = 1'b0;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.imm_src    = IMM_J;
                ctrl_o.result_src = RES_PC4;
                ctrl_o.jump       = 1'b1;
            end
            OP_JALR: begin
                // Target is rs1 + I-immediate, computed by the ALU as an add.
                ctrl_o.illegal    = 1'b0;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_PC4;
                ctrl_o.jump       = 1'b1;
            end
            OP_LUI: begin
                ctrl_o.illegal    = 1'b0;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_UIMM;
            end
            default: begin
                ctrl_o         = '0;
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/main_decoder.sv
// Registered RV32 main decoder: one-cycle latency from op to control outputs,
// synchronous active-low reset clears the whole word including Illegal.
module main_decoder
    import main_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    output logic [1:0] ResultSrc,
    output logic       MemWrite,
    output logic       Branch,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic       Jump,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUop,
    output logic       Illegal
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    main_decoder_comb u_comb (
        .op_i   (op),
        .ctrl_o (ctrl_d)
    );

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignment; reset is only sampled at
        // the clock edge and overrides the decode, so no partial word survives.
        if (!rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign RegWrite  = ctrl_q.reg_write;
    assign ImmSrc    = ctrl_q.imm_src;
    assign ALUSrc    = ctrl_q.alu_src;
    assign MemWrite  = ctrl_q.mem_write;
    assign ResultSrc = ctrl_q.result_src;
    assign Branch    = ctrl_q.branch;
    assign ALUop     = ctrl_q.alu_op;
    assign Jump      = ctrl_q.jump;
    assign Illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_main_decoder.sv
// Self-checking bench for main_decoder: directed scenarios plus randomized ops
// and resets, compared against a table-driven reference decode.
module tb_main_decoder;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Branch;
    logic       ALUSrc;
    logic       RegWrite;
    logic       Jump;
    logic [1:0] ImmSrc;
    logic [1:0] ALUop;
    logic       Illegal;

    int checks   = 0;
    int failures = 0;

    main_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .ResultSrc (ResultSrc),
        .MemWrite  (MemWrite),
        .Branch    (Branch),
        .ALUSrc    (ALUSrc),
        .RegWrite  (RegWrite),
        .Jump      (Jump),
        .ImmSrc    (ImmSrc),
        .ALUop     (ALUop),
        .Illegal   (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed word: RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUop, Jump, Illegal
    logic [11:0] obs;
    assign obs = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUop, Jump, Illegal};

    localparam logic [11:0] W_ZERO    = 12'b0_00_0_0_00_0_00_0_0;
    localparam logic [11:0] W_ILLEGAL = 12'b0_00_0_0_00_0_00_0_1;

    // Reference decode table, transcribed from the opcode/control-word list.
    logic [6:0]  ref_ops   [8];
    logic [11:0] ref_words [8];

    initial begin
        ref_ops[0] = 7'b0110011; ref_words[0] = 12'b1_00_0_0_00_0_10_0_0;
        ref_ops[1] = 7'b0010011; ref_words[1] = 12'b1_00_1_0_00_0_10_0_0;
        ref_ops[2] = 7'b0000011; ref_words[2] = 12'b1_00_1_0_01_0_00_0_0;
        ref_ops[3] = 7'b0100011; ref_words[3] = 12'b0_01_1_1_00_0_00_0_0;
        ref_ops[4] = 7'b1100011; ref_words[4] = 12'b0_10_0_0_00_1_01_0_0;
        ref_ops[5] = 7'b1101111; ref_words[5] = 12'b1_11_0_0_10_0_00_1_0;
        ref_ops[6] = 7'b1100111; ref_words[6] = 12'b1_00_1_0_10_0_00_1_0;
        ref_ops[7] = 7'b0110111; ref_words[7] = 12'b1_00_1_0_11_0_00_0_0;
    end

    function automatic logic [11:0] ref_decode(input logic [6:0] o);
        for (int i = 0; i < 8; i++)
            if (ref_ops[i] == o) return ref_words[i];
        return W_ILLEGAL;
    endfunction

    // Drive op/rst away from the edge, then sample just after the next rising edge.
    task automatic step(input logic [6:0] o, input logic r);
        @(negedge clk);
        op  = o;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(7'b0110011, 1'b0);
            checks++;
            if (obs !== W_ZERO) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, W_ZERO);
            end
        end
        step(7'b0110011, 1'b1);
        checks++;
        if (RegWrite !== 1'b1 || ALUop !== 2'b10 || Illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got RegWrite=%b ALUop=%b Illegal=%b expected 1,10,0",
                     RegWrite, ALUop, Illegal);
        end
    endtask

    task automatic test_lw_sw();
        step(7'b0000011, 1'b1);
        checks++;
        if (ResultSrc !== 2'b01 || ALUSrc !== 1'b1 || RegWrite !== 1'b1 || obs !== ref_decode(7'b0000011)) begin
            failures++;
            $display("FAIL lw: got %b expected %b", obs, ref_decode(7'b0000011));
        end
        step(7'b0100011, 1'b1);
        checks++;
        if (MemWrite !== 1'b1 || ImmSrc !== 2'b01 || RegWrite !== 1'b0 || obs !== ref_decode(7'b0100011)) begin
            failures++;
            $display("FAIL sw: got %b expected %b", obs, ref_decode(7'b0100011));
        end
    endtask

    task automatic test_branch_jump();
        step(7'b1100011, 1'b1);
        checks++;
        if (Branch !== 1'b1 || ALUop !== 2'b01 || obs !== ref_decode(7'b1100011)) begin
            failures++;
            $display("FAIL beq: got %b expected %b", obs, ref_decode(7'b1100011));
        end
        step(7'b1101111, 1'b1);
        checks++;
        if (Jump !== 1'b1 || ImmSrc !== 2'b11 || ResultSrc !== 2'b10 || obs !== ref_decode(7'b1101111)) begin
            failures++;
            $display("FAIL jal: got %b expected %b", obs, ref_decode(7'b1101111));
        end
        step(7'b1100111, 1'b1);
        checks++;
        if (Jump !== 1'b1 || ALUSrc !== 1'b1 || ImmSrc !== 2'b00 || obs !== ref_decode(7'b1100111)) begin
            failures++;
            $display("FAIL jalr: got %b expected %b", obs, ref_decode(7'b1100111));
        end
        step(7'b0110111, 1'b1);
        checks++;
        if (ResultSrc !== 2'b11 || ALUSrc !== 1'b1 || obs !== ref_decode(7'b0110111)) begin
            failures++;
            $display("FAIL lui: got %b expected %b", obs, ref_decode(7'b0110111));
        end
    endtask

    task automatic test_illegal_ends();
        logic [6:0] ends [2];
        ends[0] = 7'b0000000;
        ends[1] = 7'b1111111;
        for (int i = 0; i < 2; i++) begin
            step(ends[i], 1'b1);
            checks++;
            if (obs !== W_ILLEGAL) begin
                failures++;
                $display("FAIL illegal_op_%b: got %b expected %b", ends[i], obs, W_ILLEGAL);
            end
        end
    endtask

    task automatic test_sweep();
        int legal = 0;
        for (int o = 0; o < 128; o++) begin
            step(7'(o), 1'b1);
            checks++;
            if ($isunknown(obs) || obs !== ref_decode(7'(o))) begin
                failures++;
                $display("FAIL sweep_op_%b: got %b expected %b", 7'(o), obs, ref_decode(7'(o)));
            end
            if (Illegal === 1'b0) legal++;
        end
        checks++;
        if (legal != 8) begin
            failures++;
            $display("FAIL sweep_legal_count: got %0d expected 8", legal);
        end
    endtask

    task automatic test_reset_mid();
        step(7'b1101111, 1'b1);
        step(7'b1101111, 1'b0);
        checks++;
        if (obs !== W_ZERO) begin
            failures++;
            $display("FAIL reset_mid_jal: got %b expected %b", obs, W_ZERO);
        end
        step(7'b0010011, 1'b1);
        checks++;
        if (obs !== 12'b1_00_1_0_00_0_10_0_0) begin
            failures++;
            $display("FAIL reset_mid_ialu: got %b expected %b", obs, 12'b1_00_1_0_00_0_10_0_0);
        end
    endtask

    task automatic test_hold();
        logic [11:0] exp;
        step(7'b0000011, 1'b1);
        exp = ref_decode(7'b0000011);
        for (int i = 0; i < 3; i++) begin
            op = 7'($urandom_range(0, 127));
            #1;
        end
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_between_edges: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_random();
        logic [6:0]  o;
        logic        r;
        logic [11:0] exp;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) o = ref_ops[$urandom_range(0, 7)];
            else                            o = 7'($urandom_range(0, 127));
            r   = ($urandom_range(0, 9) != 0);
            exp = r ? ref_decode(o) : W_ZERO;
            step(o, r);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL random[%0d] op=%b rst=%b: got %b expected %b", i, o, r, obs, exp);
            end
        end
    endtask

    initial begin
        op  = 7'b0;
        rst = 1'b0;
        test_reset();
        test_lw_sw();
        test_branch_jump();
        test_illegal_ends();
        test_sweep();
        test_reset_mid();
        test_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
